booth_mul_sched: RTL

Round-robin scheduler that shares one sequential Booth multiplier core (4x4 signed operands, 9-bit product) among NUM_REQ requesters. Each requester uses a valid/ready handshake. The block grants one requester, latches its operands, and pulses start to the core. It then waits for done, with a watchdog timeout, and returns the product tagged with the requester ID over a valid/ready response channel. It sits between requester logic and the multiplier core, as its only driver.

---
 rtl/booth_sched_pkg.sv | 26 ++
 rtl/booth_mul_sched_if.sv | 43 ++++
 rtl/booth_mul_sched_rr_arbiter.sv | 39 +++
 rtl/booth_mul_sched.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/booth_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : booth_sched_pkg                                                 |
// | Brief    : Shared FSM encodings and default sizes for booth_mul_sched.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package booth_sched_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_ISSUE = ISSUE,
        S_WAIT  = WAIT,
        S_RESP  = RESP
    } state_t;

    localparam int c_DEF_WIDTH   = 4;
    localparam int c_DEF_OUT_W   = 2 * c_DEF_WIDTH + 1;
    localparam int c_DEF_TIMEOUT = 15;

endpackage
`default_nettype wire

// File: rtl/booth_mul_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : booth_mul_sched_if                                              |
// | Brief    : Request, response and core-side bundle of the Booth scheduler.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface booth_mul_sched_if
    import booth_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = c_DEF_WIDTH,
    parameter int OUT_W   = 2 * WIDTH + 1,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_in1;
    logic [NUM_REQ*WIDTH-1:0] req_in2;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [OUT_W-1:0]         rsp_data;
    logic                     rsp_err;
    logic                     mul_start;
    logic [WIDTH-1:0]         mul_in1;
    logic [WIDTH-1:0]         mul_in2;
    logic                     mul_done;
    logic [OUT_W-1:0]         mul_out;

    // Master: requesters, response consumer and multiplier core combined.
    modport master (
        output req_valid, req_in1, req_in2, rsp_ready, mul_done, mul_out,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               mul_start, mul_in1, mul_in2
    );

    modport slave (
        input  req_valid, req_in1, req_in2, rsp_ready, mul_done, mul_out,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               mul_start, mul_in1, mul_in2
    );
endinterface
`default_nettype wire

// File: rtl/booth_mul_sched_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                      |
// | Brief    : Combinational round-robin search starting at a pointer.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  wire logic [N-1:0]     req,
    input  wire logic [IDX_W-1:0] ptr,
    output logic      [N-1:0]     grant,
    output logic      [IDX_W-1:0] idx,
    output logic                  any
);

    always_comb begin
        int w_pos;
        w_pos = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            // ptr never exceeds N-1, so one subtraction gives the modulo
            w_pos = int'(ptr) + i;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (!any && req[w_pos]) begin
                any          = 1'b1;
                grant[w_pos] = 1'b1;
                idx          = IDX_W'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/booth_mul_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : booth_mul_sched                                                 |
// | Brief    : Round-robin sharing of one sequential Booth core with watchdog. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module booth_mul_sched
    import booth_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = c_DEF_WIDTH,
    parameter int OUT_W   = 2 * WIDTH + 1,
    parameter int TIMEOUT = c_DEF_TIMEOUT,
    parameter int ID_W    = 2
) (
    input wire logic         clk,
    input wire logic         rst,
    booth_mul_sched_if.slave bus
);

    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] c_LAST_ID = ID_W'(NUM_REQ - 1);

    if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(NUM_REQ)");
    end

    state_t             r_state;
    state_t             w_next;
    logic [ID_W-1:0]    r_ptr;
    logic [WIDTH-1:0]   r_op1;
    logic [WIDTH-1:0]   r_op2;
    logic [ID_W-1:0]    r_id;
    logic [OUT_W-1:0]   r_data;
    logic               r_err;
    logic               r_valid;
    logic [7:0]         r_cnt;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_start;
    logic               w_timeout;
    logic [WIDTH-1:0]   w_sel1;
    logic [WIDTH-1:0]   w_sel2;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req   (bus.req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    always_comb begin
        w_sel1 = '0;
        w_sel2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel1 = bus.req_in1[i*WIDTH +: WIDTH];
                w_sel2 = bus.req_in2[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_ready   = '0;
        w_start   = 1'b0;
        w_timeout = (r_cnt == c_TO_LAST);
        case (r_state)
            S_IDLE: begin
                w_ready = w_grant;
                if (w_any) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_start = 1'b1;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mul_done || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_id    <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_op1 <= w_sel1;
                        r_op2 <= w_sel2;
                        r_id  <= w_idx;
                        r_ptr <= (w_idx == c_LAST_ID) ? '0 : w_idx + 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    // A done landing on the timeout cycle still delivers the product
                    if (bus.mul_done) begin
                        r_data  <= bus.mul_out;
                        r_err   <= 1'b0;
                        r_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_data  <= '0;
                        r_err   <= 1'b1;
                        r_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.mul_start = w_start;
    assign bus.mul_in1   = r_op1;
    assign bus.mul_in2   = r_op2;
    assign bus.rsp_valid = r_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_data  = r_data;
    assign bus.rsp_err   = r_err;

endmodule
`default_nettype wire
